mc_control_fsm_rv32i: RTL
=========================

Name: mc_control_fsm_rv32i

Overview:
- Parametrised multi-cycle RV32I control FSM; next generation of the core's multi-cycle control unit.
- Drives the shared-memory multi-cycle datapath: PC, OldPC, IR, A/B, ALUOut and Data registers.
- Adds full branch set, JAL/JALR/LUI/AUIPC, I-type shifts, optional memory ready-handshake, illegal-opcode handling and a retired-instruction counter.

Parameters:
- MEM_WAIT, 1: 1 = memory states stall until mem_ready; 0 = mem_ready ignored, single-cycle memory.
- HALT_ON_ILLEGAL, 1: 1 = illegal opcode parks the FSM in TRAP until reset; 0 = one-cycle illegal pulse, then FETCH.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- instr  in  32  IR contents.
- zero  in  1  ALU result == 0.
- lt  in  1  signed A < B.
- ltu  in  1  unsigned A < B.
- mem_ready  in  1  memory access completes this cycle.
- mem_req  out  1  memory access request.
- adr_src  out  1  0 = PC, 1 = ALUOut.
- mem_write  out  1  store strobe.
- ir_write  out  1  IR and OldPC load.
- pc_write  out  1  PC load.
- pc_lsb_clr  out  1  clear bit0 of the PC write value.
- reg_write  out  1  register-file write.
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 A(rs1), 11 zero.
- alu_src_b  out  2  00 B(rs2), 01 imm, 10 constant 4.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt, 0110 sltu, 0111 xor, 1000 srl, 1001 sra, 1010 sll.
- illegal  out  1  illegal-instruction flag.
- instret  out  CNT_W  retired-instruction count.
- state_out  out  4  current state, for debug.

Behaviour:
- Moore outputs decoded from state (plus mem_ready/flags where stated). Unlisted outputs are 0.
- While reset=1, all strobes are forced to 0 (mem_req, mem_write, ir_write, pc_write, reg_write). On reset: state <= FETCH, instret <= 0, illegal <= 0.
- FETCH: mem_req=1, adr_src=0, A=PC, B=4, add, result_src=10.
  - ir_write and pc_write are asserted only when (mem_ready | !MEM_WAIT); FETCH is held otherwise.
- DECODE: A=OldPC, B=imm, imm_src=B, add; ALUOut gets the branch target. Next state by opcode:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_TGT
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> TRAP
- MEMADR: A=rs1, B=imm, imm_src = I (load) or S (store), add. Next MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, adr_src=1. Held until mem_ready (when MEM_WAIT=1), then MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: mem_req=1, adr_src=1. mem_write is asserted only in the completing cycle; held otherwise. Next FETCH.
- EXEC_R: A=rs1, B=rs2. alu_control from funct3, with instr[30] selecting sub/sra. Next ALUWB.
- EXEC_I: A=rs1, B=imm (I). alu_control by funct3:
  - funct3 001 = sll.
  - funct3 101 = srl, or sra when instr[30]=1.
  - Never sub.
  - Next ALUWB.
- LUI: A=zero, B=imm (U), add. AUIPC: A=OldPC, B=imm (U), add. Both go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BRANCH: A=rs1, B=rs2, sub, result_src=00.
  - pc_write = taken, where funct3 000 = zero, 001 = !zero, 100 = lt, 101 = !lt, 110 = ltu, 111 = !ltu.
  - funct3 010/011 -> TRAP with no pc_write; otherwise next FETCH.
- JAL: imm_src=J. DECODE already loaded ALUOut with OldPC+immJ. In JAL: result_src=00, pc_write=1, A=OldPC, B=4, add (link). Next ALUWB.
- JALR_TGT: A=rs1, B=imm (I), add. Next JALR_LINK.
- JALR_LINK: result_src=00, pc_write=1, pc_lsb_clr=1, A=OldPC, B=4, add. Next ALUWB.
- TRAP: illegal=1.
  - HALT_ON_ILLEGAL=1: stays in TRAP with all strobes 0 until reset.
  - HALT_ON_ILLEGAL=0: illegal is a one-cycle pulse, then FETCH.
- instret increments by 1 on exit from MEMWB, the completing MEMWRITE cycle, ALUWB and BRANCH. It wraps modulo 2^CNT_W; trapped instructions are not counted.
- A reset asserted in any state, including mid-stall, aborts the instruction without a write.

Test Plan:
- add x3,x1,x2 (0x002081B3) after reset -> states FETCH, DECODE, EXEC_R, ALUWB; alu_control=0000; reg_write in cycle 4; instret=1.
- lw with MEM_WAIT=1, mem_ready low for 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles; reg_write only in MEMWB; no extra pc_write.
- blt, funct3=100, lt=1 -> pc_write=1 in BRANCH. Same instruction with lt=0 -> pc_write=0. Both return to FETCH; instret +1 each.
- jalr x1,0(x5) -> JALR_TGT then JALR_LINK with pc_write=1, pc_lsb_clr=1, then ALUWB with reg_write=1.
- Opcode 0x7F with HALT_ON_ILLEGAL=1 -> TRAP; illegal stays 1 for 10 cycles; no strobes; reset returns to FETCH with illegal=0. With HALT_ON_ILLEGAL=0 -> one-cycle pulse, then FETCH.
- CNT_W=4: 16 ALU instructions -> instret wraps 15 -> 0; srai (instr[30]=1, funct3=101) -> alu_control=1001.

Source files
------------

// File: rtl/mc_control_fsm_rv32i.sv
// Multi-cycle RV32I control FSM: sequences the shared-memory datapath
// (PC/OldPC/IR/A/B/ALUOut/Data) and counts retired instructions.
module mc_control_fsm_rv32i #(
    parameter bit MEM_WAIT        = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_lsb_clr,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       imm_src,
    output logic [3:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_out
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;

    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11;
    localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALUWB     = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR_TGT  = 4'd11,
        S_JALR_LINK = 4'd12,
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14,
        S_TRAP      = 4'd15
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             mem_done_s, retire_s;
    logic             mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s;
    logic [2:0]       funct3_s;
    logic [6:0]       opcode_s;
    logic             alt_s;
    logic             unused_instr_s;

    // instr[30] picks sub only for register-register ops; immediates never subtract.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt, input logic allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt & allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        logic t;
        case (f3)
            3'b000:  t = z;
            3'b001:  t = ~z;
            3'b100:  t = l;
            3'b101:  t = ~l;
            3'b110:  t = lu;
            3'b111:  t = ~lu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign funct3_s       = instr[14:12];
    assign opcode_s       = instr[6:0];
    assign alt_s          = instr[30];
    assign unused_instr_s = ^{instr[31], instr[29:15], instr[11:7]};
    assign mem_done_s     = mem_ready | ~MEM_WAIT;

    // State and retired-instruction counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d     = state_q;
        retire_s    = 1'b0;
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        adr_src     = 1'b0;
        pc_lsb_clr  = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        imm_src     = IMM_I;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write_s = mem_done_s;
                pc_write_s = mem_done_s;
                state_d    = mem_done_s ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut captures OldPC+imm; JAL needs its J-immediate here.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode_s == OP_JAL) ? IMM_J : IMM_B;
                case (opcode_s)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_TGT;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode_s == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (opcode_s == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src   = 1'b1;
                state_d   = mem_done_s ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src  = RES_DATA;
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                adr_src     = 1'b1;
                mem_write_s = mem_done_s;
                retire_s    = mem_done_s;
                state_d     = mem_done_s ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC_R: begin
                alu_src_a   = SRCA_RS1;
                alu_control = alu_decode(funct3_s, alt_s, 1'b1);
                state_d     = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_control = alu_decode(funct3_s, alt_s, 1'b0);
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = SRCA_RS1;
                alu_control = ALU_SUB;
                pc_write_s  = branch_taken(funct3_s, zero, lt, ltu);
                if (funct3_s[2:1] == 2'b01) begin
                    state_d = S_TRAP;
                end else begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_JAL: begin
                imm_src    = IMM_J;
                pc_write_s = 1'b1;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                state_d    = S_ALUWB;
            end
            S_JALR_TGT: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                pc_write_s = 1'b1;
                pc_lsb_clr = 1'b1;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                state_d    = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        instret_d = retire_s ? (instret_q + {{(CNT_W-1){1'b0}}, 1'b1}) : instret_q;
    end

    // A held reset aborts any access mid-flight: no strobe escapes.
    assign mem_req   = mem_req_s   & ~reset;
    assign mem_write = mem_write_s & ~reset;
    assign ir_write  = ir_write_s  & ~reset;
    assign pc_write  = pc_write_s  & ~reset;
    assign reg_write = reg_write_s & ~reset;
    assign instret   = instret_q;
    assign state_out = state_q;

endmodule
